cipu_stream_tx: RTL and testbench

- Transmit-side driver for the CIPU check-in block. Feeds CIPU's passenger and thing input streams and consumes its done handshakes.
- A host loads a passenger list and a thing/separator command list. On start, the block streams both lists to CIPU.
- After each separator it stalls until CIPU reports done_thing, then terminates the thing stream with "$".
- Used as the on-chip stimulus source in front of CIPU.

---
 rtl/cipu_stream_tx.sv | 176 +++++++++++++++++
 tb/tb_cipu_stream_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipu_stream_tx.sv
// Streams host-loaded passenger and thing/separator lists to CIPU, one item per cycle, stalling on each separator until done_thing.
// Loads are accepted only in IDLE with neither buffer full; the optional CIPU_STREAM_TX_TIMEOUT_EN bounds the done_thing wait.
module cipu_stream_tx #(
  parameter int PDEPTH  = 16,
  parameter int TDEPTH  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [1:0] load_type,
  input  logic [7:0] load_data,
  input  logic       start,
  output logic       busy,
  output logic       tx_done,
  output logic       err,
  output logic       ready_fifo,
  output logic       ready_lifo,
  output logic [7:0] people_thing_in,
  output logic [7:0] thing_in,
  output logic [3:0] thing_num,
  input  logic       done_thing,
  input  logic       done_fifo
);

  localparam int PAW = $clog2(PDEPTH);
  localparam int TAW = $clog2(TDEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RDY, S_SEND, S_WAIT_DONE, S_TERM, S_FLUSH
  } state_t;

  state_t r_state, w_next;

  logic [7:0] r_pbuf [PDEPTH];
  logic [8:0] r_tbuf [TDEPTH];
  logic [PAW:0] r_pwr, r_prd;
  logic [TAW:0] r_twr, r_trd;
  logic [3:0] r_num;
  logic r_tx_done;

  logic w_pempty, w_pfull, w_tempty, w_tfull;
  logic w_load, w_pwe, w_twe, w_stream, w_pop_p, w_pop_t, w_sep_go, w_finish, w_tmo;
  logic [8:0] w_cmd;

  assign w_pempty = (r_pwr == r_prd);
  assign w_pfull  = (r_pwr[PAW] != r_prd[PAW]) && (r_pwr[PAW-1:0] == r_prd[PAW-1:0]);
  assign w_tempty = (r_twr == r_trd);
  assign w_tfull  = (r_twr[TAW] != r_trd[TAW]) && (r_twr[TAW-1:0] == r_trd[TAW-1:0]);

  assign load_ready = (r_state == S_IDLE) && !w_pfull && !w_tfull;
  assign w_load     = load_valid && load_ready;
  assign w_pwe      = w_load && (load_type == 2'd0);
  assign w_twe      = w_load && ((load_type == 2'd1) || (load_type == 2'd2));

  // Passenger channel free-runs from the first SEND cycle until the session ends.
  assign w_stream = (r_state == S_SEND) || (r_state == S_WAIT_DONE) ||
                    (r_state == S_TERM) || (r_state == S_FLUSH);
  assign w_pop_p  = w_stream && !w_pempty;
  assign w_cmd    = r_tbuf[r_trd[TAW-1:0]];
  assign w_pop_t  = (r_state == S_SEND) && !w_tempty;
  assign w_sep_go = w_pop_t && w_cmd[8];
  assign w_finish = (r_state == S_FLUSH) && done_fifo;
  assign busy     = (r_state != S_IDLE);
  assign tx_done  = r_tx_done;

`ifdef CIPU_STREAM_TX_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic r_err;

  assign w_tmo = (r_state == S_WAIT_DONE) && !done_thing && (r_cnt == 8'(TIMEOUT - 1));
  assign err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_sep_go) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_DONE) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  wire [31:0] w_unused_timeout = TIMEOUT;
  assign w_tmo = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    w_next          = r_state;
    ready_fifo      = 1'b0;
    ready_lifo      = 1'b0;
    thing_in        = 8'h00;
    thing_num       = 4'd0;
    people_thing_in = w_pop_p ? r_pbuf[r_prd[PAW-1:0]] : 8'h00;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RDY;
      end
      S_RDY: begin
        ready_fifo = 1'b1;
        ready_lifo = 1'b1;
        w_next     = S_SEND;
      end
      S_SEND: begin
        if (w_tempty) begin
          w_next = S_TERM;
        end else if (w_cmd[8]) begin
          thing_in  = 8'h3b;
          thing_num = w_cmd[3:0];
          w_next    = S_WAIT_DONE;
        end else begin
          thing_in = w_cmd[7:0];
        end
      end
      S_WAIT_DONE: begin
        thing_in  = 8'h3b;
        thing_num = r_num;
        if (done_thing) begin
          w_next = S_SEND;
        end else if (w_tmo) begin
          w_next = S_TERM;
        end
      end
      S_TERM: begin
        thing_in = 8'h24;
        w_next   = S_FLUSH;
      end
      S_FLUSH: begin
        if (done_fifo) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pwr     <= '0;
      r_prd     <= '0;
      r_twr     <= '0;
      r_trd     <= '0;
      r_num     <= 4'd0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tx_done <= w_finish;
      if (w_finish) begin
        r_pwr <= '0;
        r_prd <= '0;
        r_twr <= '0;
        r_trd <= '0;
      end else begin
        if (w_pwe)   r_pwr <= r_pwr + 1'b1;
        if (w_twe)   r_twr <= r_twr + 1'b1;
        if (w_pop_p) r_prd <= r_prd + 1'b1;
        if (w_pop_t) r_trd <= r_trd + 1'b1;
      end
      if (w_sep_go) r_num <= w_cmd[3:0];
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_pwe) r_pbuf[r_pwr[PAW-1:0]] <= load_data;
    if (w_twe) r_tbuf[r_twr[TAW-1:0]] <= {(load_type == 2'd2), load_data};
  end

endmodule

// File: tb/tb_cipu_stream_tx.sv
// Bench for cipu_stream_tx: expected per-cycle output traces are built from the list contents and done schedules.
module tb_cipu_stream_tx;
  localparam int PDEPTH  = 16;
  localparam int TDEPTH  = 64;
  localparam int TIMEOUT = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [1:0] load_type;
  logic [7:0] load_data;
  logic       start;
  logic       busy;
  logic       tx_done;
  logic       err;
  logic       ready_fifo;
  logic       ready_lifo;
  logic [7:0] people_thing_in;
  logic [7:0] thing_in;
  logic [3:0] thing_num;
  logic       done_thing;
  logic       done_fifo;

  always #5 clk = ~clk;

  cipu_stream_tx #(.PDEPTH(PDEPTH), .TDEPTH(TDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_type(load_type), .load_data(load_data),
    .start(start), .busy(busy), .tx_done(tx_done), .err(err),
    .ready_fifo(ready_fifo), .ready_lifo(ready_lifo),
    .people_thing_in(people_thing_in), .thing_in(thing_in), .thing_num(thing_num),
    .done_thing(done_thing), .done_fifo(done_fifo)
  );

  typedef struct packed {
    logic       lr;
    logic       busy;
    logic       txd;
    logic       err;
    logic       rf;
    logic       rl;
    logic [7:0] ppl;
    logic [7:0] thg;
    logic [3:0] num;
  } obs_t;

  typedef struct {
    logic       lv;
    logic [1:0] t;
    logic [7:0] d;
    logic       exp_rdy;
  } vec_t;

  int n_err = 0;
  int n_chk = 0;

  byte unsigned m_pass[$];
  logic [8:0]   m_cmd[$];
  int           m_wait[$];

  task automatic step();
    @(negedge clk);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = {load_ready, busy, tx_done, err, ready_fifo, ready_lifo, people_thing_in, thing_in, thing_num};
    return o;
  endfunction

  task automatic check_obs(input string name, input int idx, input obs_t exp);
    obs_t act;
    act = sample();
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got lr=%b busy=%b txd=%b err=%b rdy=%b%b ppl=%h thg=%h num=%h ; want lr=%b busy=%b txd=%b err=%b rdy=%b%b ppl=%h thg=%h num=%h",
               name, idx, act.lr, act.busy, act.txd, act.err, act.rf, act.rl, act.ppl, act.thg, act.num,
               exp.lr, exp.busy, exp.txd, exp.err, exp.rf, exp.rl, exp.ppl, exp.thg, exp.num);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic clear_model();
    m_pass.delete();
    m_cmd.delete();
    m_wait.delete();
  endtask

  task automatic do_load(input logic [1:0] t, input logic [7:0] d);
    check_bit("load_ready", load_ready, 1'b1);
    load_valid = 1'b1;
    load_type  = t;
    load_data  = d;
    step();
    load_valid = 1'b0;
    if (t == 2'd0) m_pass.push_back(d);
    else if (t == 2'd1) m_cmd.push_back({1'b0, d});
    else if (t == 2'd2) m_cmd.push_back({1'b1, d});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    clear_model();
  endtask

  // Expected trace: RDY, commands (separators held wait+1 extra cycles), empty SEND, "$", FLUSH, IDLE.
  task automatic run_trace(input int fwait);
    obs_t exp_q[$];
    bit   dt_q[$];
    bit   df_q[$];
    obs_t e;
    int   s;
    int   idle_at;
    e = '0; e.busy = 1'b1; e.rf = 1'b1; e.rl = 1'b1;
    exp_q.push_back(e); dt_q.push_back(1'b0); df_q.push_back(1'b0);
    s = 0;
    foreach (m_cmd[i]) begin
      e = '0; e.busy = 1'b1;
      if (!m_cmd[i][8]) begin
        e.thg = m_cmd[i][7:0];
        exp_q.push_back(e); dt_q.push_back(1'b0); df_q.push_back(1'b0);
      end else begin
        e.thg = 8'h3b; e.num = m_cmd[i][3:0];
        exp_q.push_back(e); dt_q.push_back(1'b0); df_q.push_back(1'b0);
        for (int w = 0; w <= m_wait[s]; w++) begin
          exp_q.push_back(e); dt_q.push_back(w == m_wait[s]); df_q.push_back(1'b0);
        end
        s++;
      end
    end
    e = '0; e.busy = 1'b1;
    exp_q.push_back(e); dt_q.push_back(1'b0); df_q.push_back(1'b0);
    e.thg = 8'h24;
    exp_q.push_back(e); dt_q.push_back(1'b0); df_q.push_back(1'b0);
    e.thg = 8'h00;
    for (int w = 0; w <= fwait; w++) begin
      exp_q.push_back(e); dt_q.push_back(1'b0); df_q.push_back(w == fwait);
    end
    idle_at = exp_q.size();
    e = '0; e.lr = 1'b1; e.txd = 1'b1;
    exp_q.push_back(e); dt_q.push_back(1'b0); df_q.push_back(1'b0);
    e.txd = 1'b0;
    exp_q.push_back(e); dt_q.push_back(1'b0); df_q.push_back(1'b0);
    for (int k = 1; k < idle_at; k++) begin
      if (k - 1 < m_pass.size()) exp_q[k].ppl = m_pass[k-1];
    end

    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check_obs("trace", k, exp_q[k]);
      done_thing = dt_q[k];
      done_fifo  = df_q[k];
      if (k < idle_at) begin
        // Stray start/load strobes while busy must have no effect.
        start      = ($urandom_range(0, 7) == 0);
        load_valid = ($urandom_range(0, 3) == 0);
        load_type  = 2'd0;
        load_data  = 8'($urandom);
      end else begin
        start      = 1'b0;
        load_valid = 1'b0;
      end
      step();
    end
    done_thing = 1'b0;
    done_fifo  = 1'b0;
    start      = 1'b0;
    load_valid = 1'b0;
    clear_model();
  endtask

  initial begin
    vec_t tbl[19];
    obs_t e;
    int   np, nc, ip, ic;

    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 2'd0, 8'(8'h61 + i), 1'b1};
    tbl[16] = '{1'b1, 2'd0, 8'h5a, 1'b0};
    tbl[17] = '{1'b1, 2'd1, 8'h78, 1'b0};
    tbl[18] = '{1'b0, 2'd0, 8'h00, 1'b0};

    rst = 1'b1; load_valid = 1'b0; load_type = 2'd0; load_data = 8'h00;
    start = 1'b0; done_thing = 1'b0; done_fifo = 1'b0;
    step();
    e = '0; e.lr = 1'b1;
    check_obs("reset", 0, e);
    step();
    rst = 1'b0;
    step();
    check_obs("post_reset", 0, e);

    // Directed: A,B,C / "1","2", sep 2
    do_load(2'd0, 8'h41); do_load(2'd0, 8'h42); do_load(2'd0, 8'h43);
    do_load(2'd1, 8'h31); do_load(2'd1, 8'h32); do_load(2'd2, 8'h02);
    m_wait.push_back(3);
    run_trace(2);

    // Separator 0 alone
    do_load(2'd2, 8'h00);
    m_wait.push_back(4);
    run_trace(1);

    // Empty session
    run_trace(0);

    // Fill passenger buffer; 17th load and a thing load are refused
    for (int i = 0; i < 19; i++) begin
      check_bit("fill_ready", load_ready, tbl[i].exp_rdy);
      load_valid = tbl[i].lv;
      load_type  = tbl[i].t;
      load_data  = tbl[i].d;
      step();
      load_valid = 1'b0;
      if (tbl[i].lv && tbl[i].exp_rdy && tbl[i].t == 2'd0) m_pass.push_back(tbl[i].d);
    end
    run_trace(16);

    // Reset asserted mid-WAIT_DONE
    do_load(2'd0, 8'h58); do_load(2'd2, 8'h05);
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    e = '0; e.busy = 1'b1; e.thg = 8'h3b; e.num = 4'd5;
    check_obs("wait_hold", 0, e);
    #2 rst = 1'b1;
    #1;
    e = '0; e.lr = 1'b1;
    check_obs("async_rst", 0, e);
    step();
    rst = 1'b0;
    clear_model();
    step();
    do_load(2'd0, 8'h51); do_load(2'd1, 8'h37);
    run_trace(0);

    // done_thing never arrives
    do_load(2'd2, 8'h03);
    start = 1'b1; step(); start = 1'b0;
    step();
    e = '0; e.busy = 1'b1; e.thg = 8'h3b; e.num = 4'd3;
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      check_obs("wait_tmo", i, e);
    end
    step();
`ifdef CIPU_STREAM_TX_TIMEOUT_EN
    e = '0; e.busy = 1'b1; e.err = 1'b1; e.thg = 8'h24;
    check_obs("timeout_term", 0, e);
`else
    check_obs("no_timeout", 0, e);
`endif
    pulse_reset();
    e = '0; e.lr = 1'b1;
    check_obs("after_tmo_rst", 0, e);

    // Randomized sessions
    for (int r = 0; r < 25; r++) begin
      np = $urandom_range(0, PDEPTH);
      nc = $urandom_range(0, 8);
      ip = 0; ic = 0;
      while (ip < np || ic < nc) begin
        case ($urandom_range(0, 5))
          0: begin
            load_valid = 1'b0;
            step();
          end
          1: do_load(2'd3, 8'($urandom));
          2, 3: if (ip < np) begin
            do_load(2'd0, 8'($urandom));
            ip++;
          end
          default: if (ic < nc) begin
            if ($urandom_range(0, 1) == 0) begin
              do_load(2'd1, 8'($urandom));
            end else begin
              do_load(2'd2, 8'($urandom));
              m_wait.push_back($urandom_range(0, 5));
            end
            ic++;
          end
        endcase
      end
      run_trace($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
